// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the 4/4/4 colour type used by
// the scanout path.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;

    localparam int MEM_LINE_PIXELS = 512;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Bundle between the scanout block, the RAM pixel read port and the VGA pins.
// master = scanout side, slave = RAM/connector side.
interface vga_scanout_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pixel_word;
    logic [9:0]       pixel_x;
    logic [9:0]       pixel_y;
    logic [3:0]       red;
    logic [3:0]       green;
    logic [3:0]       blue;
    logic             hsync;
    logic             vsync;
    logic             frame_start;

    modport master (
        input  pixel_word,
        output pixel_x, pixel_y, red, green, blue, hsync, vsync, frame_start
    );

    modport slave (
        output pixel_word,
        input  pixel_x, pixel_y, red, green, blue, hsync, vsync, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Pixel tick divider, h/v scan counters and raw (unregistered) decode of
// syncs, visible area and memory window.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       visible,
    output logic       mem_win,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start
);
    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0] div_cnt;

    assign tick = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                // Line and frame wrap share the same tick edge.
                if (h_cnt == 10'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign visible = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));
    assign mem_win = (h_cnt < 10'(MEM_LINE_PIXELS)) && (v_cnt < 10'(V_VISIBLE));

    assign hsync_n = !((h_cnt >= 10'(H_VISIBLE + H_FP)) &&
                       (h_cnt <  10'(H_VISIBLE + H_FP + H_SYNC)));
    assign vsync_n = !((v_cnt >= 10'(V_VISIBLE + V_FP)) &&
                       (v_cnt <  10'(V_VISIBLE + V_FP + V_SYNC)));

    // div_cnt resets to 0, so this stays low through reset for CLK_DIV >= 2.
    assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: addresses the RAM screen region, picks the displayed bit and
// drives RGB/syncs. Define VGA_SCANOUT_BORDER_EN to paint a blue border.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int          WIDTH                   = 16,
    parameter int          BITS_PER_MEMORY_PIXEL_X = 2,
    parameter int          BITS_PER_MEMORY_PIXEL_Y = 2,
    parameter int          CLK_DIV                 = 2,
    parameter logic [11:0] FG_COLOR                = 12'hFFF,
    parameter logic [11:0] BG_COLOR                = 12'h000
) (
    input logic           CPUclk,
    input logic           resetN,
    vga_scanout_if.master bus
);
    localparam int IW = $clog2(WIDTH);

    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       visible;
    logic       mem_win;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_start;

    vga_timing #(
        .CLK_DIV(CLK_DIV)
    ) u_timing (
        .clk        (CPUclk),
        .rst_n      (resetN),
        .tick       (tick),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .visible    (visible),
        .mem_win    (mem_win),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .frame_start(frame_start)
    );

    // Vertical replication is done by the RAM's addressing, not here.
    localparam int UNUSED_Y_SCALE = BITS_PER_MEMORY_PIXEL_Y;

    assign bus.pixel_x = mem_win ? h_cnt : '0;
    assign bus.pixel_y = mem_win ? v_cnt : '0;

    logic [IW-1:0] bit_idx;
    logic          bit_on;
    logic          border;

    // MSB is the leftmost memory pixel of each word.
    assign bit_idx = IW'(WIDTH - 1 - (int'(h_cnt >> BITS_PER_MEMORY_PIXEL_X) % WIDTH));
    assign bit_on  = bus.pixel_word[bit_idx];

`ifdef VGA_SCANOUT_BORDER_EN
    assign border = visible &&
                    (!mem_win || (v_cnt == '0) || (v_cnt == 10'(V_VISIBLE - 1)));
`else
    assign border = 1'b0;
`endif

    function automatic rgb_t pick_color(input logic vis, input logic mw,
                                        input logic on, input logic brd);
        rgb_t c;
        c = '0;
        if (vis && mw) begin
            c = on ? rgb_t'(FG_COLOR) : rgb_t'(BG_COLOR);
        end
        if (brd) begin
            c = rgb_t'(12'h00F);
        end
        return c;
    endfunction

    rgb_t rgb_p1;
    logic hsync_p1;
    logic vsync_p1;

    // Output stage: colour and syncs for the pre-advance counters, so they
    // share one tick of latency and never skew.
    always_ff @(posedge CPUclk or negedge resetN) begin
        if (!resetN) begin
            rgb_p1   <= '0;
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
        end else if (tick) begin
            rgb_p1   <= pick_color(visible, mem_win, bit_on, border);
            hsync_p1 <= hsync_n;
            vsync_p1 <= vsync_n;
        end
    end

    assign bus.red         = rgb_p1.r;
    assign bus.green       = rgb_p1.g;
    assign bus.blue        = rgb_p1.b;
    assign bus.hsync       = hsync_p1;
    assign bus.vsync       = vsync_p1;
    assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: random RAM image, expected scan per tick
// computed from position arithmetic, monitor compares once per pixel tick.
module tb_vga_scanout;
    localparam int          WIDTH   = 16;
    localparam int          BX      = 2;
    localparam int          BY      = 2;
    localparam int          CLK_DIV = 2;
    localparam logic [11:0] FG      = 12'hA5C;
    localparam logic [11:0] BG      = 12'h3C1;
    localparam int          PX      = 1 << BX;
    localparam int          PY      = 1 << BY;
    localparam int          WPL     = 512 / (PX * WIDTH);
    localparam int          NWORDS  = (480 / PY) * WPL;

    logic CPUclk = 1'b0;
    logic resetN = 1'b0;
    always #5 CPUclk = ~CPUclk;

    vga_scanout_if #(.WIDTH(WIDTH)) bus ();

    vga_scanout #(
        .WIDTH                  (WIDTH),
        .BITS_PER_MEMORY_PIXEL_X(BX),
        .BITS_PER_MEMORY_PIXEL_Y(BY),
        .CLK_DIV                (CLK_DIV),
        .FG_COLOR               (FG),
        .BG_COLOR               (BG)
    ) dut (
        .CPUclk(CPUclk),
        .resetN(resetN),
        .bus   (bus.master)
    );

    logic [WIDTH-1:0] mem [0:NWORDS-1];

    // RAM model: registered read, one CPUclk latency.
    always @(posedge CPUclk)
        bus.pixel_word <= mem[(int'(bus.pixel_y) / PY) * WPL + int'(bus.pixel_x) / (PX * WIDTH)];

    typedef struct packed {
        logic [9:0]  px;
        logic [9:0]  py;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   mon_n       = 0;
    bit   mon_done    = 1'b0;
    event go;

    function automatic logic [11:0] color_at(input int h, input int v);
        logic [WIDTH-1:0] w;
        logic [11:0]      c;
        bit               vis;
        bit               inmem;
        vis   = (h < 640) && (v < 480);
        inmem = (h < 512) && (v < 480);
        c     = 12'h000;
        if (vis && inmem) begin
            w = mem[(v / PY) * WPL + h / (PX * WIDTH)];
            c = w[WIDTH - 1 - (h / PX) % WIDTH] ? FG : BG;
        end
`ifdef VGA_SCANOUT_BORDER_EN
        if (vis && (!inmem || v == 0 || v == 479)) c = 12'h00F;
`endif
        return c;
    endfunction

    // Expected bus state during the j-th pixel tick period after reset release.
    function automatic exp_t model(input int j);
        exp_t e;
        int   h, v, hp, vp;
        h    = j % 800;
        v    = (j / 800) % 525;
        e.px = (h < 512 && v < 480) ? 10'(h) : 10'd0;
        e.py = (h < 512 && v < 480) ? 10'(v) : 10'd0;
        e.fs = (h == 0 && v == 0);
        if (j == 0) begin
            e.rgb = 12'h000;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end else begin
            hp    = (j - 1) % 800;
            vp    = ((j - 1) / 800) % 525;
            e.rgb = color_at(hp, vp);
            e.hs  = !(hp >= 656 && hp < 752);
            e.vs  = !(vp >= 490 && vp < 492);
        end
        return e;
    endfunction

    function automatic exp_t sample_bus();
        return {bus.pixel_x, bus.pixel_y, bus.red, bus.green, bus.blue,
                bus.hsync, bus.vsync, bus.frame_start};
    endfunction

    // Monitor: one sample in the last CPUclk of every tick period.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(go);
            for (int j = 0; j < mon_n; j++) begin
                repeat ((j == 0) ? CLK_DIV - 1 : CLK_DIV) @(posedge CPUclk);
                @(negedge CPUclk);
                got = sample_bus();
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL scan tick %0d: no expected entry, got %h", j, got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL scan tick %0d: got px=%0d py=%0d rgb=%h hs=%b vs=%b fs=%b, expected px=%0d py=%0d rgb=%h hs=%b vs=%b fs=%b",
                                 j, got.px, got.py, got.rgb, got.hs, got.vs, got.fs,
                                 e.px, e.py, e.rgb, e.hs, e.vs, e.fs);
                    end
                end
            end
            mon_done = 1'b1;
        end
    end

    task automatic run_phase(input int n);
        for (int j = 0; j < n; j++) exp_q.push_back(model(j));
        mon_done = 1'b0;
        mon_n    = n;
        @(negedge CPUclk);
        resetN = 1'b1;
        ->go;
        for (int c = 0; c < n * CLK_DIV + 20 && !mon_done; c++) @(posedge CPUclk);
        if (!mon_done) begin
            miscompares++;
            $display("FAIL phase timeout: monitor done=%b, required 1", mon_done);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $fatal(1, "scan monitor did not complete");
        end
    endtask

    initial begin
        exp_t got;
        exp_t rst_exp;
        for (int i = 0; i < NWORDS; i++) mem[i] = WIDTH'($urandom);
        mem[0] = 16'hF000;
        mem[1] = 16'h0F00;
        rst_exp = {10'd0, 10'd0, 12'h000, 1'b1, 1'b1, 1'b0};

        resetN = 1'b0;
        repeat (3) @(negedge CPUclk);
        got = sample_bus();
        vectors++;
        if (got !== rst_exp) begin
            miscompares++;
            $display("FAIL reset state: got %h, expected %h", got, rst_exp);
        end

        // Scan lines 0..20 up to h=300, then pull reset mid-line.
        run_phase(20 * 800 + 301);
        #2 resetN = 1'b0;
        #1 got = sample_bus();
        vectors++;
        if (got !== rst_exp) begin
            miscompares++;
            $display("FAIL async reset mid-line: got %h, expected %h", got, rst_exp);
        end

        repeat (3) @(negedge CPUclk);
        run_phase(3 * 800 + 20);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
